pipe_adder_n: RTL and testbench
===============================

PIPE_ADDER_N -- requirements
Module: pipe_adder_n

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of SEG.
REQ-002 Parameter SEG, default 4, bits added per pipeline stage; STAGES = WIDTH/SEG, at least 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand beat valid.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 c_in  input  1  carry-in; ignored when sub=1.
REQ-009 sub  input  1  0 = a+b+c_in, 1 = a-b (two's complement, carry-in forced 1, b inverted).
REQ-010 out_valid  output  1  result beat valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 sum  output  WIDTH  result.
REQ-013 c_out  output  1  raw carry out of MSB; in sub mode 1 = no borrow.
REQ-014 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 A beat SHALL be accepted when in_valid and in_ready are both 1.
REQ-016 Stage k (0..STAGES-1) SHALL add segment k of a and b' plus the registered carry from stage k-1 (stage 0 uses c_in or 1); upper segments SHALL be delayed in registers until their stage.
REQ-017 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when out_ready is held 1.
REQ-018 Pipeline advance enable SHALL be (!out_valid || out_ready); all stages SHALL hold when it is 0.
REQ-019 in_ready SHALL equal the advance enable, combinationally; throughput one beat per cycle when not stalled.
REQ-020 out_valid, sum, c_out, ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 Bubbles (in_valid=0) SHALL propagate as invalid stages; no result SHALL be produced for them.
REQ-022 Without saturation, sum SHALL wrap modulo 2^WIDTH.
REQ-023 sub and c_in SHALL be captured at acceptance and travel with the beat.

Reset
REQ-024 When rst=1 at a clock edge, all stage valid bits, out_valid, sum, c_out and ovf SHALL become 0.
REQ-025 In-flight beats SHALL be discarded on reset; in_ready SHALL be 1 in the first cycle after reset releases.
REQ-026 rst SHALL take priority over acceptance and advance in the same cycle.

Configuration
REQ-027 Macro PIPE_ADDER_SAT_EN defined: unsigned saturation; add with c_out=1 gives sum all-ones, sub with c_out=0 gives sum 0; c_out and ovf still report raw values.
REQ-028 Macro PIPE_ADDER_SAT_EN undefined: no saturation logic; sum wraps per REQ-022.

Structure
REQ-029 Shared package SHALL hold default WIDTH/SEG constants and a derived STAGES helper function.
REQ-030 One sub-module seg_adder (SEG-bit ripple adder, inputs a, b, c_in; outputs sum, c_out, c_msb_in) SHALL be instantiated once per stage.

Verification (WIDTH=16, SEG=4)
REQ-031 a=0xFFFF, b=0x0001, c_in=0, sub=0 -> after 4 cycles sum=0x0000, c_out=1, ovf=0.
REQ-032 a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, c_out=0, ovf=0; with PIPE_ADDER_SAT_EN sum=0x0000.
REQ-033 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1, c_out=0.
REQ-034 Eight back-to-back beats, out_ready low for cycles 5-7 -> in_ready low for those cycles, all eight results in order, none lost or duplicated.
REQ-035 rst pulsed with 3 beats in flight -> no out_valid afterwards until new beats arrive; in_ready=1 in the cycle after release.

Source files
------------

// File: rtl/pipe_adder_n_pkg.sv
// Shared constants and helpers for the segmented pipelined adder.
package pipe_adder_n_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

  // Number of pipeline stages for a given operand width and segment size.
  function automatic int calc_stages(input int width, input int seg);
    int n;
    n = width / seg;
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/pipe_adder_n_seg_adder.sv
// SEG-bit ripple-carry adder; also exposes the carry into its top bit for overflow detection.
module seg_adder #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           c_in,
  output logic [SEG-1:0] sum,
  output logic           c_out,
  output logic           c_msb_in
);

  logic [SEG:0] c;

  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = c_in;
    for (int i = 0; i < SEG; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign c_out    = c[SEG];
  assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/pipe_adder_n.sv
// Pipelined add/subtract, one SEG-bit segment per stage, valid/ready flow control.
// Optional unsigned saturation when PIPE_ADDER_SAT_EN is defined.
module pipe_adder_n
  import pipe_adder_n_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int STAGES = calc_stages(WIDTH, SEG);

  logic             adv;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             ovf_q;

  // The whole pipeline moves together; a stalled output freezes every stage.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // Stage k owns the registers that feed it; stage 0 works straight off the inputs.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-k*SEG-1:0] op_a;
    logic [WIDTH-k*SEG-1:0] op_b;
    logic                   op_v;
    logic                   op_sub;
    logic                   op_c;
    logic [(k+1)*SEG-1:0]   res_sum;
    logic [SEG-1:0]         seg_sum;
    logic                   seg_co;
    logic                   seg_cm;

    if (k == 0) begin : g_in
      assign op_a    = a;
      assign op_b    = sub ? ~b : b;
      assign op_v    = in_valid;
      assign op_sub  = sub;
      assign op_c    = sub | c_in;
      assign res_sum = seg_sum;
    end else begin : g_reg
      logic                   v_q;
      logic                   sub_q;
      logic                   c_q;
      logic [WIDTH-k*SEG-1:0] a_q;
      logic [WIDTH-k*SEG-1:0] b_q;
      logic [k*SEG-1:0]       sum_lo_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
        end else if (adv) begin
          v_q <= g_stage[k-1].op_v;
        end
      end

      // NOTE: datapath registers carry no reset; the valid bit alone qualifies them.
      always_ff @(posedge clk) begin
        if (adv) begin
          sub_q    <= g_stage[k-1].op_sub;
          c_q      <= g_stage[k-1].seg_co;
          a_q      <= g_stage[k-1].op_a[WIDTH-(k-1)*SEG-1:SEG];
          b_q      <= g_stage[k-1].op_b[WIDTH-(k-1)*SEG-1:SEG];
          sum_lo_q <= g_stage[k-1].res_sum;
        end
      end

      assign op_a    = a_q;
      assign op_b    = b_q;
      assign op_v    = v_q;
      assign op_sub  = sub_q;
      assign op_c    = c_q;
      assign res_sum = {seg_sum, sum_lo_q};
    end

    seg_adder #(.SEG(SEG)) u_seg (
      .a        (op_a[SEG-1:0]),
      .b        (op_b[SEG-1:0]),
      .c_in     (op_c),
      .sum      (seg_sum),
      .c_out    (seg_co),
      .c_msb_in (seg_cm)
    );

    // Only the top segment's MSB carry-in matters for signed overflow.
    if (k != STAGES - 1) begin : g_cm_sink
      logic unused_cm;
      assign unused_cm = seg_cm;
    end
  end

  logic [WIDTH-1:0] final_sum;
  logic [WIDTH-1:0] sat_sum;
  logic             final_v;
  logic             final_sub;
  logic             final_co;
  logic             final_cm;

  assign final_sum = g_stage[STAGES-1].res_sum;
  assign final_v   = g_stage[STAGES-1].op_v;
  assign final_sub = g_stage[STAGES-1].op_sub;
  assign final_co  = g_stage[STAGES-1].seg_co;
  assign final_cm  = g_stage[STAGES-1].seg_cm;

`ifdef PIPE_ADDER_SAT_EN
  // Unsigned clamp: add overflow pins high, subtract borrow pins low.
  always_comb begin
    sat_sum = final_sum;
    if (!final_sub && final_co) begin
      sat_sum = '1;
    end else if (final_sub && !final_co) begin
      sat_sum = '0;
    end
  end
`else
  logic unused_sub;
  assign unused_sub = final_sub;
  assign sat_sum    = final_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= final_v;
      sum_q       <= sat_sum;
      c_out_q     <= final_co;
      ovf_q       <= final_cm ^ final_co;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder_n.sv
// Self-checking bench for pipe_adder_n (WIDTH=16, SEG=4): directed vectors, stall, reset, random traffic.
module tb_pipe_adder_n;

  localparam int W = 16;
  localparam int S = 4;
`ifdef PIPE_ADDER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  pipe_adder_n #(.WIDTH(W), .SEG(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
  } res_t;

  res_t         exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           n_out    = 0;
  bit           hold_pend = 1'b0;
  logic [W-1:0] held_sum;
  logic         held_co;
  logic         held_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: plain wide addition, overflow from operand/result signs.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mci, input logic msb);
    res_t         r;
    logic [W-1:0] bx;
    logic [W:0]   full;
    bx    = msb ? ~mb : mb;
    full  = {1'b0, ma} + {1'b0, bx} + ((msb | mci) ? (W+1)'(1) : (W+1)'(0));
    r.sum = full[W-1:0];
    r.co  = full[W];
    r.ovf = (ma[W-1] == bx[W-1]) && (full[W-1] != ma[W-1]);
    if (SAT_EN) begin
      if (!msb && r.co) r.sum = '1;
      if (msb && !r.co) r.sum = '0;
    end
    return r;
  endfunction

  // One clock cycle: inputs are set by the caller at the falling edge.
  task automatic step();
    res_t e;
    #1;
    check("in_ready_rule", in_ready, !out_valid || out_ready);
    if (hold_pend) begin
      check("hold_valid", out_valid, 1);
      check("hold_sum", sum, held_sum);
      check("hold_cout", c_out, held_co);
      check("hold_ovf", ovf, held_ovf);
    end
    hold_pend = !rst && out_valid && !out_ready;
    held_sum  = sum;
    held_co   = c_out;
    held_ovf  = ovf;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) exp_q.push_back(model(a, b, c_in, sub));
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sum", sum, e.sum);
          check("c_out", c_out, e.co);
          check("ovf", ovf, e.ovf);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] da, input logic [W-1:0] db,
                          input logic dci, input logic dsb, input logic [W-1:0] es,
                          input logic eco, input logic eovf);
    int lat;
    a = da; b = db; c_in = dci; sub = dsb;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, S);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, c_out, eco);
    check({tag, "_ovf"}, ovf, eovf);
    step();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
    check("drain_empty", exp_q.size(), 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n0;
    int sent;
    bit acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    @(negedge clk);
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", c_out, 0);
    check("reset_ovf", ovf, 0);
    check("reset_in_ready", in_ready, 1);
    @(negedge clk);

    directed("wrap_add", 16'hFFFF, 16'h0001, 1'b0, 1'b0, SAT_EN ? 16'hFFFF : 16'h0000, 1'b1, 1'b0);
    directed("borrow_sub", 16'h0005, 16'h0007, 1'b0, 1'b1, SAT_EN ? 16'h0000 : 16'hFFFE, 1'b0, 1'b0);
    directed("sub_cin_ignored", 16'h0005, 16'h0007, 1'b1, 1'b1, SAT_EN ? 16'h0000 : 16'hFFFE, 1'b0, 1'b0);
    directed("signed_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("add_cin", 16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
    directed("sub_no_borrow", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Eight back-to-back beats with the output stalled in cycles 5..7.
    n0 = n_out;
    sent = 0;
    for (int c = 0; c < 40 && !(sent == 8 && n_out - n0 == 8); c++) begin
      in_valid  = (sent < 8);
      a = W'($urandom); b = W'($urandom);
      c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      out_ready = !(c >= 5 && c <= 7);
      #1;
      if (c < 12) check("b2b_in_ready", in_ready, !(c >= 5 && c <= 7));
      acc = in_valid && in_ready;
      step();
      if (acc) sent++;
    end
    check("b2b_sent", sent, 8);
    check("b2b_received", n_out - n0, 8);
    drain();

    // Reset with three beats in flight; a beat offered during reset must be dropped.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = W'($urandom); b = W'($urandom); c_in = 1'b0; sub = 1'b0;
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_sum", sum, 0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_idle", out_valid, 0);
    end
    directed("after_rst", 16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Random traffic with random back-pressure and bubbles.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a = pick(); b = pick();
      c_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
